// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// The transmitter uses these now, and a future receiver is meant to reuse them.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer. It counts 0..CLKS_PER_BIT-1 while run is high and is held at 0 otherwise.
// bit_done is high on the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign bit_done = run && (cnt == LAST);
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input.
// All outputs are driven from flops, so tx is glitch-free and in_ready/busy depend only on state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS != 8) begin : g_bad_bits
        $error("uart_tx: DATA_BITS must be 8");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 bit_done;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .run      (state != IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    shreg    <= in_data;
                    bit_idx  <= '0;
                    state    <= START;
                    tx       <= 1'b0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                START: if (bit_done) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (bit_done) begin
                    shreg <= shreg >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        // The next bit is bit 1 of the register before this shift takes effect.
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= shreg[1];
                    end
                end
                STOP: if (bit_done) begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 4 clocks/bit and one at 2 clocks/bit.
// A serial receiver model decodes the tx line of either instance.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data4 = '0, in_data2 = '0;
    logic       in_valid4 = 1'b0, in_valid2 = 1'b0;
    logic       in_ready4, in_ready2, tx4, tx2, busy4, busy2;
    int         tests = 0, fails = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .tx(tx4), .busy(busy4));
    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2));

    function automatic logic txsel(input int which);
        return (which != 0) ? tx2 : tx4;
    endfunction

    // Receiver model: wait for the start bit, then sample each bit at its centre.
    // It returns on the centre cycle of the stop bit.
    task automatic rx_frame(input int which, input int cpb, input int limit,
                            output logic [7:0] b, output int t_start, output bit ok);
        ok = 1'b0; b = '0; t_start = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txsel(which) == 1'b0) begin ok = 1'b1; t_start = cyc; break; end
        end
        if (!ok) return;
        repeat (cpb / 2) @(negedge clk);
        if (txsel(which) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = txsel(which);
        end
        repeat (cpb) @(negedge clk);
        if (txsel(which) !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({tx4, in_ready4, busy4, tx2, in_ready2, busy2} !== 6'b110_110) begin
            fails++;
            $display("FAIL reset_state: got %b want 110110",
                     {tx4, in_ready4, busy4, tx2, in_ready2, busy2});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if ({tx4, in_ready4, busy4} !== 3'b110) begin
                fails++;
                $display("FAIL idle_cycle%0d: got %b want 110", i, {tx4, in_ready4, busy4});
            end
        end
    endtask

    task automatic test_a5();
        logic [9:0] frame;
        frame = 10'b1_1010_0101_0;
        in_data4 = 8'hA5; in_valid4 = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            tests++;
            if (in_ready4 !== (c == 41)) begin
                fails++;
                $display("FAIL a5_in_ready c%0d: got %b want %b", c, in_ready4, c == 41);
            end
            if (c <= 40 && (c % 4) == 3) begin
                tests++;
                if (tx4 !== frame[c / 4]) begin
                    fails++;
                    $display("FAIL a5_bit%0d: got %b want %b", c / 4, tx4, frame[c / 4]);
                end
            end
        end
    endtask

    // Holds in_valid with a new byte right after the first acceptance and checks frame spacing.
    task automatic two_frames(input logic [7:0] b0, input logic [7:0] b1,
                              input int change_at, input string tag);
        int t0, s0, s1;
        bit ok0, ok1, acc;
        logic [7:0] r0, r1;
        in_data4 = b0; in_valid4 = 1'b1; t0 = cyc;
        fork
            begin
                acc = 1'b0;
                repeat (change_at) @(negedge clk);
                in_data4 = b1;
                tests++;
                if (in_ready4 !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_ready_midframe: got %b want 0", tag, in_ready4);
                end
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (in_ready4) begin acc = 1'b1; break; end
                end
                @(negedge clk);
                in_valid4 = 1'b0;
            end
            begin
                rx_frame(0, 4, 20, r0, s0, ok0);
                rx_frame(0, 4, 60, r1, s1, ok1);
            end
        join
        tests++;
        if (!acc) begin fails++; $display("FAIL %s_accept: got timeout want in_ready", tag); end
        tests++;
        if ({ok0, ok1} !== 2'b11) begin
            fails++;
            $display("FAIL %s_framing: got %b want 11", tag, {ok0, ok1});
        end
        tests++;
        if (r0 !== b0) begin fails++; $display("FAIL %s_byte0: got %h want %h", tag, r0, b0); end
        tests++;
        if (r1 !== b1) begin fails++; $display("FAIL %s_byte1: got %h want %h", tag, r1, b1); end
        tests++;
        if (s0 - t0 !== 1) begin
            fails++;
            $display("FAIL %s_start0: got cycle %0d want 1", tag, s0 - t0);
        end
        tests++;
        if (s1 - t0 !== 42) begin
            fails++;
            $display("FAIL %s_start1: got cycle %0d want 42", tag, s1 - t0);
        end
    endtask

    task automatic test_back_to_back();
        two_frames(8'h00, 8'hFF, 1, "b2b");
    endtask

    task automatic test_data_change();
        two_frames(8'hC3, 8'h3C, 10, "chg");
    endtask

    task automatic test_reset_midframe();
        int bad;
        in_data4 = 8'h00; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (16) @(negedge clk);
        tests++;
        if (tx4 !== 1'b0) begin fails++; $display("FAIL rst_pre_tx: got %b want 0", tx4); end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({tx4, busy4} !== 2'b10) begin
            fails++;
            $display("FAIL rst_async: got tx,busy=%b want 10", {tx4, busy4});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready4, busy4} !== 2'b10) begin
            fails++;
            $display("FAIL rst_after: got ready,busy=%b want 10", {in_ready4, busy4});
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rst_residual: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_cpb2_random();
        logic [7:0] q[$];
        fork
            begin
                logic [7:0] v;
                bit acc;
                for (int n = 0; n < 100; n++) begin
                    v = 8'($urandom_range(0, 255));
                    in_data2 = v; in_valid2 = 1'b1;
                    acc = 1'b0;
                    for (int i = 0; i < 60; i++) begin
                        if (in_ready2) begin acc = 1'b1; break; end
                        @(negedge clk);
                    end
                    @(negedge clk);
                    if (acc) q.push_back(v);
                end
                in_valid2 = 1'b0;
            end
            begin
                logic [7:0] r, e;
                int s, prev;
                bit ok;
                prev = 0;
                for (int n = 0; n < 100; n++) begin
                    rx_frame(1, 2, 60, r, s, ok);
                    e = (q.size() > 0) ? q.pop_front() : 8'hxx;
                    tests++;
                    if (!ok || r !== e) begin
                        fails++;
                        $display("FAIL cpb2_byte%0d: got %h ok=%b want %h", n, r, ok, e);
                    end
                    tests++;
                    if (busy2 !== 1'b1) begin
                        fails++;
                        $display("FAIL cpb2_busy_end%0d: got %b want 1", n, busy2);
                    end
                    @(negedge clk);
                    tests++;
                    if ({busy2, tx2} !== 2'b01) begin
                        fails++;
                        $display("FAIL cpb2_len%0d: got busy,tx=%b want 01", n, {busy2, tx2});
                    end
                    if (n > 0) begin
                        tests++;
                        if (s - prev !== 21) begin
                            fails++;
                            $display("FAIL cpb2_spacing%0d: got %0d want 21", n, s - prev);
                        end
                    end
                    prev = s;
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_a5();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (50) @(negedge clk);
        test_data_change();
        repeat (50) @(negedge clk);
        test_reset_midframe();
        test_cpb2_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
